hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//  Owns the six 7-segment HEX outputs of the NIOS base platform and shares them between two requesters:
//  req0 = CPU-side PIO bridge, req1 = hardware status source.
//  Round-robin arbitration accepts one 24-bit value (6 nibbles) per transaction.
//  An FSM decodes the value one digit per cycle into a shadow bank, with optional leading-zero blanking.
//  All six displays then update in a single cycle, so no tearing is visible.
// PARAMETERS
//  NUM_DIGITS   6    digits driven; data width = 4*NUM_DIGITS
//  ACTIVE_LOW   1    1: segment on = 0 (DE-board HEX); 0: segment on = 1
// PORTS
//  clk_clk       in   1   system clock, single domain
//  reset_reset   in   1   asynchronous, active-high reset
//  req0_valid    in   1   requester 0 has a value
//  req0_data     in   24  requester 0 value; nibble k -> hexk
//  req0_blank_lz in   1   requester 0 leading-zero blanking request
//  req0_ready    out  1   requester 0 value accepted this cycle
//  req1_valid    in   1   as req0
//  req1_data     in   24  as req0
//  req1_blank_lz in   1   as req0
//  req1_ready    out  1   as req0
//  busy          out  1   transaction in progress (not IDLE)
//  last_grant    out  1   id of the most recently accepted requester
//  hex0..hex5    out  7   segments {g,f,e,d,c,b,a}, per ACTIVE_LOW
// BEHAVIOUR
//  Reset values: hexN = blank (7'h7F when ACTIVE_LOW), readies = 0, busy = 0, last_grant = 1 (so req0 wins first).
//  Shadow bank and digit counter are also cleared by reset.
//  Handshake:
//   - valid/ready; a transfer occurs on a rising edge where valid && ready.
//   - Requester holds valid and data stable until ready.
//   - readyX is combinational; it is asserted only in IDLE, and only for the granted requester.
//  Arbitration in IDLE:
//   - Only one valid -> grant it.
//   - Both valid -> grant the id != last_grant.
//   - On accept: latch data and blank_lz; last_grant <= id.
//  FSM states:
//   - IDLE -> CONVERT on accept.
//   - CONVERT: digit counter d runs 5 down to 0. Each cycle, decode nibble d into shadow[d]. At d == 0 -> COMMIT.
//   - COMMIT: hex0..hex5 <= shadow in one edge -> IDLE.
//  Latency:
//   - Accept edge = E. CONVERT spans 6 cycles. hexN outputs change on edge E+7. busy is high for cycles E+1..E+7.
//   - Next accept is possible at edge E+8 (at most one transaction per 8 cycles).
//  Blanking, when the latched blank_lz = 1:
//   - Walking from hex5 down, zero nibbles are blanked until the first non-zero nibble.
//   - hex0 is never blanked, so value 0 shows "0".
//   - An interior zero after a non-zero digit is displayed as "0".
//  Decode: 0-9, A, b, C, d, E, F in standard 7-seg glyphs. ACTIVE_LOW inverts the pattern.
//  Valid dropped while not ready: no effect. Valid asserted while busy: held off until IDLE, then arbitrated normally.
//  Reset mid-transaction: abort immediately, outputs go to blank, the pending value is discarded; requester must re-present.
//  Outputs are registered; no combinational path from data to hexN.
// STRUCTURE
//  hex_display_pkg:
//   - state typedef {IDLE, CONVERT, COMMIT}
//   - SEG_BLANK constant
//   - seg7_glyph nibble->segment constant table
//  Sub-module hex7seg_decode: combinational nibble + blank + ACTIVE_LOW -> 7 bits. One instance, time-shared across digits by the FSM.
//  Top level holds arbiter, FSM, digit counter, 6x7 shadow bank and output registers.
// TESTING
//  1. Reset, then req0 value 24'h12AB3F, blank_lz = 0 -> hex5..hex0 = 1,2,A,b,3,F at edge E+7; busy high 7 cycles.
//  2. req1 value 24'h000450, blank_lz = 1 -> hex5..hex3 blank, hex2 = 4, hex1 = 5, hex0 = 0.
//  3. Value 0, blank_lz = 1 -> hex5..hex1 blank, hex0 = "0".
//  4. Both valid continuously for 4 transactions -> grants alternate 0,1,0,1; accepts 8 cycles apart.
//  5. Assert reset at CONVERT d = 3 -> all hex blank, busy = 0; the re-presented value completes normally.
//  6. Values change only at COMMIT: sample hexN every cycle of CONVERT -> previous pattern held on all six digits.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the HEX display controller.
// Segment patterns are stored active-high as {g,f,e,d,c,b,a}.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_e;

    localparam int unsigned MAX_DIGITS = 6;
    localparam logic [6:0]  SEG_BLANK  = 7'h00;

    // Index n holds the glyph for nibble n: 0-9, A, b, C, d, E, F.
    localparam logic [15:0][6:0] SEG7_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble-to-segment decoder with blanking and output polarity.
module hex7seg_decode
    import hex_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    logic [6:0] w_pattern;

    always_comb begin
        w_pattern = i_blank ? SEG_BLANK : SEG7_GLYPH[i_nibble];
        o_seg     = seg_polarity(w_pattern, ACTIVE_LOW);
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Two-requester round-robin front end for the six HEX displays: decodes one digit
// per cycle into a shadow bank, then updates every display on the same edge.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    req0_valid,
    input  logic [4*NUM_DIGITS-1:0] req0_data,
    input  logic                    req0_blank_lz,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [4*NUM_DIGITS-1:0] req1_data,
    input  logic                    req1_blank_lz,
    output logic                    req1_ready,
    output logic                    busy,
    output logic                    last_grant,
    output logic [6:0]              hex0,
    output logic [6:0]              hex1,
    output logic [6:0]              hex2,
    output logic [6:0]              hex3,
    output logic [6:0]              hex4,
    output logic [6:0]              hex5
);

    localparam int unsigned DW        = 4 * NUM_DIGITS;
    localparam logic [2:0]  DIGIT_TOP = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]  BLANK_OUT = seg_polarity(SEG_BLANK, ACTIVE_LOW);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_last_grant;
    logic [DW-1:0] r_data;
    logic        r_lz_active;
    logic [2:0]  r_digit;
    logic [6:0]  r_shadow [MAX_DIGITS];
    logic [6:0]  r_hex    [MAX_DIGITS];

    logic        w_idle;
    logic        w_grant;
    logic        w_accept;
    logic [3:0]  w_nibble;
    logic        w_blank;
    logic [6:0]  w_seg;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        w_idle     = (r_state == IDLE) && !reset_reset;
        w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_accept   = w_idle && (req0_valid || req1_valid);
        req0_ready = w_accept && !w_grant;
        req1_ready = w_accept && w_grant;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = CONVERT;
            CONVERT: if (r_digit == 3'd0) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leading-zero blanking stays armed until the first non-zero digit; hex0 always shows.
    always_comb begin
        w_nibble = r_data[{r_digit, 2'b00} +: 4];
        w_blank  = r_lz_active && (w_nibble == 4'h0) && (r_digit != 3'd0);
    end

    hex7seg_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_last_grant <= 1'b1;
            r_data       <= '0;
            r_lz_active  <= 1'b0;
            r_digit      <= 3'd0;
            for (int k = 0; k < MAX_DIGITS; k++) begin
                r_shadow[k] <= BLANK_OUT;
                r_hex[k]    <= BLANK_OUT;
            end
        end else begin
            if (w_accept) begin
                r_data       <= w_grant ? req1_data : req0_data;
                r_lz_active  <= w_grant ? req1_blank_lz : req0_blank_lz;
                r_last_grant <= w_grant;
                r_digit      <= DIGIT_TOP;
            end
            if (r_state == CONVERT) begin
                r_shadow[r_digit] <= w_seg;
                if (w_nibble != 4'h0) begin
                    r_lz_active <= 1'b0;
                end
                if (r_digit != 3'd0) begin
                    r_digit <= r_digit - 3'd1;
                end
            end
            if (r_state == COMMIT) begin
                for (int k = 0; k < MAX_DIGITS; k++) begin
                    r_hex[k] <= r_shadow[k];
                end
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign last_grant = r_last_grant;
    assign hex0       = r_hex[0];
    assign hex1       = r_hex[1];
    assign hex2       = r_hex[2];
    assign hex3       = r_hex[3];
    assign hex4       = r_hex[4];
    assign hex5       = r_hex[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: expected display images are queued at
// accept time and compared when the commit edge is due.
module tb_hex_display_ctrl;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_blank_lz, req0_ready;
    logic        req1_valid, req1_blank_lz, req1_ready;
    logic [23:0] req0_data, req1_data;
    logic        busy, last_grant;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [41:0] hex_all;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [41:0] exp_q[$];
    logic [41:0] exp_prev;
    logic        tb_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    hex_display_ctrl dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .req0_valid    (req0_valid),
        .req0_data     (req0_data),
        .req0_blank_lz (req0_blank_lz),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_data     (req1_data),
        .req1_blank_lz (req1_blank_lz),
        .req1_ready    (req1_ready),
        .busy          (busy),
        .last_grant    (last_grant),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Expected {hex5..hex0} image, active-low.
    function automatic logic [41:0] model(input logic [23:0] v, input logic blz);
        logic [41:0] img;
        logic        lead;
        logic [3:0]  nib;
        logic [6:0]  seg;
        lead = blz;
        img  = '0;
        for (int k = 5; k >= 0; k--) begin
            nib = v[4*k +: 4];
            if (lead && nib == 4'h0 && k != 0) begin
                seg = 7'h00;
            end else begin
                seg  = glyph(nib);
                lead = 1'b0;
            end
            img[7*k +: 7] = ~seg;
        end
        return img;
    endfunction

    // Present a value on one requester and wait (bounded) for it to be accepted.
    // Returns at accept edge + 1ns with valid dropped and the expectation queued.
    task automatic send(input logic id, input logic [23:0] data, input logic blz, output bit ok);
        ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_data = data; req1_blank_lz = blz;
        end else begin
            req0_valid = 1'b1; req0_data = data; req0_blank_lz = blz;
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
            exp_q.push_back(model(data, blz));
            tb_last = id;
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (hex_all !== ALL_BLANK) begin
            n_fail++; $display("FAIL reset_hex got=%h exp=%h", hex_all, ALL_BLANK);
        end
        n_tests++;
        if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl busy=%b r0=%b r1=%b exp=0", busy, req0_ready, req1_ready);
        end
        n_tests++;
        if (last_grant !== 1'b1) begin
            n_fail++; $display("FAIL reset_last_grant got=%b exp=1", last_grant);
        end
        req0_valid = 1'b0;
        rst = 1'b0;
        tb_last = 1'b1;
        exp_prev = ALL_BLANK;
        @(posedge clk);
        #1;
    endtask

    // Plain decode, leading-zero blanking, zero value, interior zeros; display held during CONVERT.
    task automatic test_decode_vectors();
        logic [23:0] vdata [5] = '{24'h12AB3F, 24'h000450, 24'h000000, 24'h00A0F0, 24'h89CDE7};
        logic        vblz  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        vid   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bit          ok;
        int          bad_busy, bad_hold;
        logic [41:0] exp;
        for (int t = 0; t < 5; t++) begin
            send(vid[t], vdata[t], vblz[t], ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL vec%0d_accept got=timeout exp=ready", t);
                return;
            end
            n_tests++;
            if (last_grant !== vid[t]) begin
                n_fail++; $display("FAIL vec%0d_last_grant got=%b exp=%b", t, last_grant, vid[t]);
            end
            bad_busy = 0;
            bad_hold = 0;
            for (int k = 0; k < 7; k++) begin
                if (busy !== 1'b1) bad_busy++;
                if (hex_all !== exp_prev) bad_hold++;
                @(posedge clk);
                #1;
            end
            n_tests++;
            if (bad_busy != 0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_busy low_cycles=%0d busy_after=%b exp=7_high_then_0",
                         t, bad_busy, busy);
            end
            n_tests++;
            if (bad_hold != 0) begin
                n_fail++; $display("FAIL vec%0d_hold changed_cycles=%0d exp=0", t, bad_hold);
            end
            exp = exp_q.pop_front();
            n_tests++;
            if (hex_all !== exp) begin
                n_fail++; $display("FAIL vec%0d_commit got=%h exp=%h", t, hex_all, exp);
            end
            exp_prev = exp;
        end
    endtask

    task automatic test_held_off();
        bit          ok;
        int          bad;
        logic [41:0] exp;
        send(1'b1, 24'h0FACE0, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL held_accept got=timeout exp=ready");
            return;
        end
        req0_valid = 1'b1; req0_data = 24'h000007; req0_blank_lz = 1'b1;
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL held_ready_while_busy bad_cycles=%0d exp=0", bad);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (hex_all !== exp) begin
            n_fail++; $display("FAIL held_first_commit got=%h exp=%h", hex_all, exp);
        end
        exp_prev = exp;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL held_ready_at_idle got=%b exp=1", req0_ready);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(model(24'h000007, 1'b1));
        tb_last = 1'b0;
        req0_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (hex_all !== exp) begin
            n_fail++; $display("FAIL held_second_commit got=%h exp=%h", hex_all, exp);
        end
        exp_prev = exp;
    endtask

    task automatic test_round_robin();
        logic [23:0] rr_data [2];
        logic        exp_id;
        logic [41:0] exp;
        bit          ok;
        int          last_acc;
        int          acc;
        rr_data[0] = 24'h0A0B0C;
        rr_data[1] = 24'h123456;
        req0_data = rr_data[0]; req0_blank_lz = 1'b0; req0_valid = 1'b1;
        req1_data = rr_data[1]; req1_blank_lz = 1'b0; req1_valid = 1'b1;
        last_acc = 0;
        for (int t = 0; t < 4; t++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk);
            end
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL rr%0d_accept got=timeout exp=ready", t);
                break;
            end
            exp_id = ~tb_last;
            n_tests++;
            if (req1_ready !== exp_id || req0_ready !== ~exp_id) begin
                n_fail++;
                $display("FAIL rr%0d_grant r0=%b r1=%b exp_id=%b", t, req0_ready, req1_ready, exp_id);
            end
            exp_q.push_back(model(rr_data[exp_id], 1'b0));
            @(posedge clk);
            #1;
            acc = cyc;
            if (t > 0) begin
                n_tests++;
                if (acc - last_acc != 8) begin
                    n_fail++; $display("FAIL rr%0d_spacing got=%0d exp=8", t, acc - last_acc);
                end
            end
            last_acc = acc;
            tb_last = exp_id;
            rr_data[exp_id] = rr_data[exp_id] + 24'h010101;
            if (exp_id) req1_data = rr_data[1];
            else        req0_data = rr_data[0];
            repeat (7) @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            n_tests++;
            if (hex_all !== exp) begin
                n_fail++; $display("FAIL rr%0d_commit got=%h exp=%h", t, hex_all, exp);
            end
            exp_prev = exp;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit          ok;
        logic [41:0] exp;
        send(1'b1, 24'h654321, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_accept got=timeout exp=ready");
            return;
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b1 || hex_all !== exp_prev) begin
            n_fail++; $display("FAIL mid_before busy=%b hex=%h exp_hex=%h", busy, hex_all, exp_prev);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (hex_all !== ALL_BLANK || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort hex=%h busy=%b exp=%h/0", hex_all, busy, ALL_BLANK);
        end
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_last = 1'b1;
        exp_prev = ALL_BLANK;
        n_tests++;
        if (last_grant !== 1'b1) begin
            n_fail++; $display("FAIL mid_last_grant got=%b exp=1", last_grant);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (hex_all !== ALL_BLANK || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_discard hex=%h busy=%b exp=%h/0", hex_all, busy, ALL_BLANK);
        end
        send(1'b1, 24'h654321, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_represent got=timeout exp=ready");
            return;
        end
        repeat (7) @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (hex_all !== exp) begin
            n_fail++; $display("FAIL mid_commit got=%h exp=%h", hex_all, exp);
        end
        exp_prev = exp;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_blank_lz = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_blank_lz = 1'b0;
        exp_prev = ALL_BLANK;
        tb_last = 1'b1;
        test_reset();
        test_decode_vectors();
        test_held_off();
        test_round_robin();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
